// File: rtl/reflet_irq_source_pkg.sv
// reflet_irq_source_pkg
// Shared definitions for the interrupt request source: register map
// addresses and the number of interrupt lines.
package reflet_irq_source_pkg;

    localparam int irq_lines = 4;

    typedef enum logic [1:0] {
        irq_addr_pending = 2'd0,
        irq_addr_enable  = 2'd1,
        irq_addr_mode    = 2'd2,
        irq_addr_timer   = 2'd3
    } irq_addr_t;

endpackage

// File: rtl/reflet_irq_source_line.sv
// reflet_irq_line
// One interrupt line: synchronizer chain, edge history, level/edge
// selection and the pending latch.
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   event_in  asynchronous device event
//   mode      0 = level, 1 = rising edge
//   set       extra set source (timer tick), independent of mode
//   clear     write-1-to-clear strobe for this line
//   pending   latched request
module reflet_irq_line #(
    parameter int sync_stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic event_in,
    input  logic mode,
    input  logic set,
    input  logic clear,
    output logic pending
);

    logic [sync_stages-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   set_cond;

    assign s = sync_q[sync_stages-1];

    // Edge mode requires the previous synchronized sample to be low.
    assign set_cond = s & (~mode | ~prev_q);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the shift chain depends on it).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q  <= {sync_q[sync_stages-2:0], event_in};
            // prev tracks s in every mode so a later switch to edge mode
            // does not see a stale low and fire a spurious edge.
            prev_q  <= s;
            // Set takes priority over a simultaneous clear.
            pending <= set_cond | set | (pending & ~clear);
        end
    end

endmodule

// File: rtl/reflet_irq_source.sv
// reflet_irq_source
// Peripheral interrupt request generator. Four asynchronous event lines are
// synchronized, qualified by level/edge mode, latched as pending and masked by
// enable to drive the ext_int level bus.
//
// Optional feature: define REFLET_IRQ_TIMER_EN to add a periodic timer on
// line 3 controlled by the TIMER_RELOAD register (addr 3).
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   event_in  [3:0] asynchronous device events
//   addr      [1:0] register select (0 PENDING, 1 ENABLE, 2 MODE, 3 TIMER_RELOAD)
//   data_in   [wordsize-1:0] write data
//   write_en  register write strobe
//   read_en   register read strobe
//   data_out  [wordsize-1:0] read data, valid the cycle after read_en, else 0
//   ext_int   [3:0] interrupt levels (pending & enable)
module reflet_irq_source
    import reflet_irq_source_pkg::*;
#(
    parameter int wordsize    = 16,
    parameter int sync_stages = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [irq_lines-1:0] event_in,
    input  logic [1:0]           addr,
    input  logic [wordsize-1:0]  data_in,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [wordsize-1:0]  data_out,
    output logic [irq_lines-1:0] ext_int
);

    irq_addr_t            reg_sel;
    logic [irq_lines-1:0] pending;
    logic [irq_lines-1:0] enable_q;
    logic [irq_lines-1:0] mode_q;
    logic [irq_lines-1:0] clear_vec;
    logic [irq_lines-1:0] ext_set;
    logic [wordsize-1:0]  rd_val;
    logic                 tick;

    assign reg_sel   = irq_addr_t'(addr);
    assign clear_vec = (write_en && reg_sel == irq_addr_pending) ? data_in[irq_lines-1:0] : '0;
    assign ext_set   = {tick, {(irq_lines-1){1'b0}}};
    assign ext_int   = pending & enable_q;

    for (genvar n = 0; n < irq_lines; n++) begin : g_line
        reflet_irq_line #(
            .sync_stages(sync_stages)
        ) u_line (
            .clk     (clk),
            .reset   (reset),
            .event_in(event_in[n]),
            .mode    (mode_q[n]),
            .set     (ext_set[n]),
            .clear   (clear_vec[n]),
            .pending (pending[n])
        );
    end

`ifdef REFLET_IRQ_TIMER_EN
    logic [wordsize-1:0] reload_q;
    logic [wordsize-1:0] count_q;

    // Tick fires in the cycle the counter sits at 0 while running; the
    // period is therefore reload+1 cycles.
    assign tick = (reload_q != '0) && (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
            count_q  <= '0;
        end else if (write_en && reg_sel == irq_addr_timer) begin
            reload_q <= data_in;
            count_q  <= data_in;
        end else if (reload_q != '0) begin
            count_q <= tick ? reload_q : count_q - 1'b1;
        end
    end
`else
    logic unused_data_in;

    assign tick           = 1'b0;
    assign unused_data_in = ^data_in[wordsize-1:irq_lines];
`endif

    // NOTE: every variable driven here receives a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            irq_addr_pending: rd_val[irq_lines-1:0] = pending;
            irq_addr_enable:  rd_val[irq_lines-1:0] = enable_q;
            irq_addr_mode:    rd_val[irq_lines-1:0] = mode_q;
            irq_addr_timer: begin
`ifdef REFLET_IRQ_TIMER_EN
                rd_val = reload_q;
`endif
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= '0;
            mode_q   <= '0;
            data_out <= '0;
        end else begin
            // Sampled from pre-edge state, so a same-cycle write is not seen.
            data_out <= read_en ? rd_val : '0;
            if (write_en && reg_sel == irq_addr_enable) enable_q <= data_in[irq_lines-1:0];
            if (write_en && reg_sel == irq_addr_mode)   mode_q   <= data_in[irq_lines-1:0];
        end
    end

endmodule
